// File: rtl/vga_fb_sched_pkg.sv
// Shared geometry defaults and fetch state type for the framebuffer scheduler.
`timescale 1ns/1ps
package vga_pkg;
    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned DATA_W    = 24;
    localparam int unsigned ADDR_W    = 19;
    localparam int unsigned CPU_EVERY = 8;

    typedef enum logic [1:0] {IDLE, FETCH, LAST} fetch_state_t;
endpackage

// File: rtl/vga_line_buf.sv
// Ping-pong line buffer: two banks of H_ACTIVE pixels, one sync write port, one async read port.
`timescale 1ns/1ps
module vga_line_buf #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned DATA_W   = 24
) (
    input  logic                        pclk,
    input  logic                        wr_en,
    input  logic                        wr_bank,
    input  logic [$clog2(H_ACTIVE)-1:0] wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_bank,
    input  logic [$clog2(H_ACTIVE)-1:0] rd_idx,
    output logic [DATA_W-1:0]           rd_data
);
    localparam int unsigned A_W = $clog2(2 * H_ACTIVE);

    logic [DATA_W-1:0] mem [2 * H_ACTIVE];
    logic [A_W-1:0]    wr_a;
    logic [A_W-1:0]    rd_a;

    assign wr_a = (wr_bank ? A_W'(H_ACTIVE) : '0) + A_W'(wr_idx);
    assign rd_a = (rd_bank ? A_W'(H_ACTIVE) : '0) + A_W'(rd_idx);

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wr_a] <= wr_data;
        end
    end

    assign rd_data = mem[rd_a];
endmodule

// File: rtl/vga_fb_sched.sv
// Shares one single-port framebuffer SRAM between VGA line prefetch and CPU pixel writes.
`timescale 1ns/1ps
module vga_fb_sched #(
    parameter int unsigned H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int unsigned DATA_W    = vga_pkg::DATA_W,
    parameter int unsigned ADDR_W    = vga_pkg::ADDR_W,
    parameter int unsigned CPU_EVERY = vga_pkg::CPU_EVERY
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              vga_valid,
    input  logic [9:0]        vga_h_addr,
    input  logic [9:0]        vga_v_addr,
    input  logic              vga_vsync,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              underrun
);
    import vga_pkg::*;

    localparam int unsigned FB_DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int unsigned IDX_W    = $clog2(H_ACTIVE);
    localparam int unsigned SLOT_W   = $clog2(CPU_EVERY + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_addr;
    logic              bank;
    logic [IDX_W-1:0]  rd_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic              vsync_q;
    logic              valid_q;
    logic              ready_en;
    logic              cap_en;
    logic              cap_bank;
    logic [IDX_W-1:0]  cap_idx;

    logic              frame_trig;
    logic              line_trig;
    logic              trig;
    logic              cpu_slot;
    logic              rd_issue;
    logic              cpu_go;
    logic [DATA_W-1:0] lb_data;

    always_comb begin
        frame_trig   = vga_vsync & ~vsync_q;
        line_trig    = vga_valid & ~valid_q & (vga_h_addr == '0)
                     & (vga_v_addr != 10'(V_ACTIVE - 1));
        trig         = frame_trig | line_trig;
        cpu_slot     = (state == FETCH) && (slot_cnt == SLOT_W'(CPU_EVERY));
        rd_issue     = (state == FETCH) && !cpu_slot;
        cpu_wr_ready = ready_en & ((state != FETCH) | cpu_slot);
        cpu_go       = cpu_wr_valid & cpu_wr_ready & (cpu_wr_addr < ADDR_W'(FB_DEPTH));
    end

    always_comb begin
        mem_en    = rd_issue | cpu_go;
        mem_we    = cpu_go;
        mem_addr  = cpu_go ? cpu_wr_addr : fetch_addr + ADDR_W'(rd_cnt);
        mem_wdata = cpu_go ? cpu_wr_data : '0;
    end

    // vsync_q resets high so a vsync already high at release is not taken as an edge.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fetch_addr <= '0;
            bank       <= 1'b0;
            rd_cnt     <= '0;
            slot_cnt   <= '0;
            vsync_q    <= 1'b1;
            valid_q    <= 1'b0;
            ready_en   <= 1'b0;
            underrun   <= 1'b0;
            cap_en     <= 1'b0;
            cap_bank   <= 1'b0;
            cap_idx    <= '0;
        end else begin
            vsync_q  <= vga_vsync;
            valid_q  <= vga_valid;
            ready_en <= 1'b1;
            underrun <= 1'b0;
            cap_en   <= rd_issue;
            cap_bank <= bank;
            cap_idx  <= rd_cnt;
            if (trig) begin
                underrun <= (state != IDLE);
                state    <= FETCH;
                rd_cnt   <= '0;
                slot_cnt <= '0;
                if (frame_trig) begin
                    fetch_addr <= '0;
                    bank       <= 1'b0;
                end else begin
                    bank <= ~vga_v_addr[0];
                    // An aborted fetch still consumes its line of address space.
                    if (state == FETCH) begin
                        fetch_addr <= fetch_addr + ADDR_W'(H_ACTIVE);
                    end
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (cpu_slot) begin
                            slot_cnt <= '0;
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                            if (rd_cnt == IDX_W'(H_ACTIVE - 1)) begin
                                state      <= LAST;
                                fetch_addr <= fetch_addr + ADDR_W'(H_ACTIVE);
                            end else begin
                                rd_cnt <= rd_cnt + 1'b1;
                            end
                        end
                    end
                    LAST:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    vga_line_buf #(
        .H_ACTIVE (H_ACTIVE),
        .DATA_W   (DATA_W)
    ) u_line_buf (
        .pclk    (pclk),
        .wr_en   (cap_en),
        .wr_bank (cap_bank),
        .wr_idx  (cap_idx),
        .wr_data (mem_rdata),
        .rd_bank (vga_v_addr[0]),
        .rd_idx  (IDX_W'(vga_h_addr)),
        .rd_data (lb_data)
    );

    assign vga_data = (vga_valid && vga_h_addr < 10'(H_ACTIVE)) ? lb_data : '0;
endmodule

// File: tb/tb_vga_fb_sched.sv
// Directed/random bench for vga_fb_sched against an SRAM model and a pixel-level reference.
`timescale 1ns/1ps
module tb_vga_fb_sched;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int FB = H * V;

    logic        pclk = 1'b0;
    logic        reset_n;
    logic        vga_valid;
    logic [9:0]  vga_h_addr;
    logic [9:0]  vga_v_addr;
    logic        vga_vsync;
    logic [23:0] vga_data;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [18:0] cpu_wr_addr;
    logic [23:0] cpu_wr_data;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] sram   [0:FB-1];
    bit          sram_v [0:FB-1];
    int          n_wr_strobes = 0;
    logic [23:0] model_wr [int];
    int          wr_x [$];

    always #5 pclk = ~pclk;

    vga_fb_sched #(
        .H_ACTIVE (640), .V_ACTIVE (480), .DATA_W (24), .ADDR_W (19), .CPU_EVERY (8)
    ) dut (
        .pclk (pclk), .reset_n (reset_n),
        .vga_valid (vga_valid), .vga_h_addr (vga_h_addr), .vga_v_addr (vga_v_addr),
        .vga_vsync (vga_vsync), .vga_data (vga_data),
        .cpu_wr_valid (cpu_wr_valid), .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr (cpu_wr_addr), .cpu_wr_data (cpu_wr_data),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .underrun (underrun)
    );

    function automatic logic [23:0] init_val(input int a);
        return 24'(a * 37 + 11);
    endfunction

    function automatic logic [23:0] ref_val(input int a);
        if (model_wr.exists(a)) return model_wr[a];
        return init_val(a);
    endfunction

    // SRAM: one-cycle read latency, pre-filled with init_val.
    always @(posedge pclk) begin
        if (mem_en && mem_we) n_wr_strobes <= n_wr_strobes + 1;
        if (mem_en && int'(mem_addr) < FB) begin
            if (mem_we) begin
                sram[mem_addr]   <= mem_wdata;
                sram_v[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= sram_v[mem_addr] ? sram[mem_addr] : init_val(int'(mem_addr));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic trig_line(input int y);
        step(); vga_valid = 1'b0;
        step(); vga_valid = 1'b1; vga_h_addr = 10'd0; vga_v_addr = 10'(y);
    endtask

    task automatic trig_frame();
        step(); vga_vsync = 1'b0;
        step(); vga_vsync = 1'b1;
    endtask

    task automatic run_fetch(input int base, input bit cpu_on, input int stop_reads,
                             input string tag, output int n_under, output bit first_under);
        int cyc, n_reads, first_rd, last_rd, bad_seq, bad_pat, bad_wr, ev;
        cyc = 0; n_reads = 0; first_rd = -1; last_rd = -1;
        bad_seq = 0; bad_pat = 0; bad_wr = 0; ev = 0; n_under = 0; first_under = 1'b0;
        while (n_reads < stop_reads && cyc < 1000) begin
            step();
            cpu_wr_valid = cpu_on;
            cpu_wr_addr  = 19'(3 * H + $urandom_range(H - 1, 1));
            cpu_wr_data  = 24'($urandom);
            @(negedge pclk);
            if (underrun) n_under++;
            if (cyc == 0) first_under = underrun;
            if (cpu_wr_valid && cpu_wr_ready) begin
                if (!(mem_en && mem_we && mem_addr == cpu_wr_addr && mem_wdata == cpu_wr_data))
                    bad_wr++;
                model_wr[int'(cpu_wr_addr)] = cpu_wr_data;
                wr_x.push_back(int'(cpu_wr_addr) - 3 * H);
                if (first_rd >= 0) begin
                    if (ev % 9 != 8) bad_pat++;
                    ev++;
                end
            end else if (mem_en && mem_we) begin
                bad_wr++;
            end else if (mem_en) begin
                if (int'(mem_addr) != base + n_reads) bad_seq++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (cpu_on && ev % 9 == 8) bad_pat++;
                ev++;
                n_reads++;
            end
            cyc++;
        end
        cpu_wr_valid = 1'b0;
        chk({tag, "_done"}, 32'(n_reads), 32'(stop_reads));
        chk({tag, "_addr_seq"}, 32'(bad_seq), 32'd0);
        chk({tag, "_span"}, 32'(last_rd - first_rd), 32'((stop_reads - 1) + (stop_reads - 1) / 8));
        chk({tag, "_cpu_wr"}, 32'(bad_wr), 32'd0);
        if (cpu_on) chk({tag, "_slot_pattern"}, 32'(bad_pat), 32'd0);
    endtask

    task automatic fetch_full(input int base, input bit cpu_on, input string tag);
        int nu;
        bit fu;
        run_fetch(base, cpu_on, H, tag, nu, fu);
        chk({tag, "_no_underrun"}, 32'(nu), 32'd0);
        step();
        step();
    endtask

    task automatic disp(input int y, input int x, input int line, input string tag);
        step();
        vga_valid = 1'b1; vga_v_addr = 10'(y); vga_h_addr = 10'(x);
        @(negedge pclk);
        chk(tag, 32'(vga_data), 32'(ref_val(line * H + x)));
    endtask

    initial begin
        int nu, cnt, strobes;
        bit fu;
        reset_n = 1'b0; vga_valid = 1'b0; vga_h_addr = '0; vga_v_addr = '0;
        vga_vsync = 1'b1; cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;

        @(negedge pclk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_vga_data", 32'(vga_data), 32'd0);
        step(); reset_n = 1'b1;
        step(); @(negedge pclk);
        chk("rdy_after_release", 32'(cpu_wr_ready), 32'd1);

        // Frame start: line 0 into bank 0, no CPU traffic
        trig_frame();
        fetch_full(0, 1'b0, "frame_fetch");
        disp(0, 5, 0, "line0_x5");
        for (int i = 0; i < 3; i++) disp(0, $urandom_range(H - 1, 1), 0, "line0_rand");
        step(); vga_valid = 1'b0; @(negedge pclk);
        chk("data_zero_invalid", 32'(vga_data), 32'd0);

        // Line 1 fetched while the CPU streams writes into line 3
        wr_x.delete();
        trig_line(0);
        fetch_full(H, 1'b1, "cpu_fetch");
        chk("cpu_writes_in_fetch", 32'(wr_x.size()), 32'd79);
        trig_line(1);
        fetch_full(2 * H, 1'b0, "line2_fetch");
        trig_line(2);
        fetch_full(3 * H, 1'b0, "line3_fetch");
        disp(2, $urandom_range(H - 1, 1), 2, "line2_rand");
        for (int i = 0; i < 4; i++) disp(3, wr_x[i * 17], 3, "line3_written");
        disp(3, $urandom_range(H - 1, 1), 3, "line3_rand");

        // Walk to line 10, whose trigger fetches line 11 into bank 1
        for (int y = 3; y < 10; y++) fetch_full_line(y);
        trig_line(10);
        fetch_full(11 * H, 1'b0, "line11_fetch");
        for (int i = 0; i < 3; i++) disp(11, $urandom_range(H - 1, 1), 11, "line11_rand");

        trig_line(V - 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(); @(negedge pclk);
            if (mem_en) cnt++;
        end
        chk("no_trig_last_line", 32'(cnt), 32'd0);

        // Abort: second trigger arrives ~300 cycles into the fetch of line 12
        trig_line(11);
        run_fetch(12 * H, 1'b0, 266, "abort_first", nu, fu);
        chk("abort_first_no_underrun", 32'(nu), 32'd0);
        trig_line(12);
        run_fetch(13 * H, 1'b0, H, "after_abort", nu, fu);
        chk("underrun_pulse_first", 32'(fu), 32'd1);
        chk("underrun_pulse_count", 32'(nu), 32'd1);
        step(); step();
        for (int i = 0; i < 3; i++) disp(13, $urandom_range(H - 1, 1), 13, "line13_rand");
        step(); vga_valid = 1'b0;

        // Out-of-range CPU write is accepted and dropped; in-range write goes out
        strobes = n_wr_strobes;
        step(); cpu_wr_valid = 1'b1; cpu_wr_addr = 19'(FB); cpu_wr_data = 24'($urandom);
        @(negedge pclk);
        chk("oor_ready", 32'(cpu_wr_ready), 32'd1);
        chk("oor_mem_en", 32'(mem_en), 32'd0);
        step(); cpu_wr_valid = 1'b1; cpu_wr_addr = 19'd12345; cpu_wr_data = 24'hA5C3E1;
        @(negedge pclk);
        chk("wr_mem_en", 32'(mem_en), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'd12345);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5C3E1);
        step(); cpu_wr_valid = 1'b0;
        @(negedge pclk);
        chk("oor_no_sram_write", 32'(n_wr_strobes - strobes), 32'd1);

        // Reset in the middle of a fetch
        trig_line(13);
        run_fetch(14 * H, 1'b0, 100, "pre_reset", nu, fu);
        step(); reset_n = 1'b0; vga_valid = 1'b0;
        #1;
        chk("midfetch_rst_mem_en", 32'(mem_en), 32'd0);
        chk("midfetch_rst_underrun", 32'(underrun), 32'd0);
        step(); step(); reset_n = 1'b1;
        step(); @(negedge pclk);
        chk("midfetch_rdy_after_release", 32'(cpu_wr_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(); @(negedge pclk);
            if (mem_en || underrun) cnt++;
        end
        chk("quiet_after_reset", 32'(cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic fetch_full_line(input int y);
        trig_line(y);
        fetch_full((y + 1) * H, 1'b0, "walk_fetch");
    endtask
endmodule
